// File: rtl/phy_pkg.sv
// Shared constants and types for the PHY receive synchronization logic.
package phy_pkg;

    localparam logic [7:0] COMMA_CHAR   = 8'hBC;
    localparam int         SYNC_CNT_DEF = 4;
    localparam int         LOSS_CNT_DEF = 4;

    typedef enum logic {
        SEARCH = 1'b0,
        SYNC   = 1'b1
    } lane_state_e;

endpackage

// File: rtl/phy_lane_sync.sv
// Per-lane comma hunt / sync-hold FSM. data_ok_o flags a non-idle, error-free
// byte seen while this lane is in SYNC.
module phy_lane_sync
    import phy_pkg::*;
#(
    parameter int              DATA_W   = 8,
    parameter logic [DATA_W-1:0] COMMA  = COMMA_CHAR,
    parameter int              SYNC_CNT = SYNC_CNT_DEF,
    parameter int              LOSS_CNT = LOSS_CNT_DEF
) (
    input  logic              clk_f,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_i,
    input  logic              err_i,
    output logic              in_sync_o,
    output logic              data_ok_o
);

    localparam logic [2:0] SYNC_LAST = 3'(SYNC_CNT - 1);
    localparam logic [2:0] LOSS_LAST = 3'(LOSS_CNT - 1);

    lane_state_e state_q, state_d;
    logic [2:0]  ccnt_q, ccnt_d;
    logic [2:0]  ecnt_q, ecnt_d;
    logic        is_comma;

    assign is_comma  = (data_i == COMMA);
    assign in_sync_o = (state_q == SYNC);

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            state_q <= SEARCH;
            ccnt_q  <= 3'd0;
            ecnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            ccnt_q  <= ccnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

    // Errors outrank commas in SYNC; an errored comma never counts toward sync.
    always_comb begin
        state_d   = state_q;
        ccnt_d    = ccnt_q;
        ecnt_d    = ecnt_q;
        data_ok_o = 1'b0;
        if (!enable) begin
            state_d = SEARCH;
            ccnt_d  = 3'd0;
            ecnt_d  = 3'd0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (is_comma && !err_i) begin
                        if (ccnt_q == SYNC_LAST) begin
                            state_d = SYNC;
                            ccnt_d  = 3'd0;
                        end else begin
                            ccnt_d = ccnt_q + 3'd1;
                        end
                    end else begin
                        ccnt_d = 3'd0;
                    end
                end
                SYNC: begin
                    if (err_i) begin
                        if (ecnt_q == LOSS_LAST) begin
                            state_d = SEARCH;
                            ecnt_d  = 3'd0;
                        end else begin
                            ecnt_d = ecnt_q + 3'd1;
                        end
                    end else begin
                        ecnt_d    = 3'd0;
                        data_ok_o = !is_comma;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    ccnt_d  = 3'd0;
                    ecnt_d  = 3'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// Two-lane receive sync controller: lanes sync independently, but data is only
// released while both lanes are in SYNC.
module phy_rx_sync_ctrl
    import phy_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] COMMA    = COMMA_CHAR,
    parameter int                SYNC_CNT = SYNC_CNT_DEF,
    parameter int                LOSS_CNT = LOSS_CNT_DEF
) (
    input  logic              clk_f,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic              err_in_0,
    input  logic              err_in_1,
    output logic [DATA_W-1:0] data_out_0,
    output logic [DATA_W-1:0] data_out_1,
    output logic              valid_out_0,
    output logic              valid_out_1,
    output logic              sync_0,
    output logic              sync_1,
    output logic              active_out
);

    logic              in_sync_0, in_sync_1;
    logic              data_ok_0, data_ok_1;
    logic              both_sync;
    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic              valid0_q, valid0_d, valid1_q, valid1_d;

    phy_lane_sync #(
        .DATA_W(DATA_W), .COMMA(COMMA), .SYNC_CNT(SYNC_CNT), .LOSS_CNT(LOSS_CNT)
    ) u_lane0 (
        .clk_f(clk_f), .reset(reset), .enable(enable),
        .data_i(data_in_0), .err_i(err_in_0),
        .in_sync_o(in_sync_0), .data_ok_o(data_ok_0)
    );

    phy_lane_sync #(
        .DATA_W(DATA_W), .COMMA(COMMA), .SYNC_CNT(SYNC_CNT), .LOSS_CNT(LOSS_CNT)
    ) u_lane1 (
        .clk_f(clk_f), .reset(reset), .enable(enable),
        .data_i(data_in_1), .err_i(err_in_1),
        .in_sync_o(in_sync_1), .data_ok_o(data_ok_1)
    );

    assign both_sync = in_sync_0 & in_sync_1;

    // A lane keeps loading its data bytes even while the other lane lags,
    // but valid is only raised once both state registers are in SYNC.
    always_comb begin
        data0_d  = data_ok_0 ? data_in_0 : data0_q;
        data1_d  = data_ok_1 ? data_in_1 : data1_q;
        valid0_d = data_ok_0 & both_sync;
        valid1_d = data_ok_1 & both_sync;
    end

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            data0_q  <= '0;
            data1_q  <= '0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
        end else begin
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
        end
    end

    assign data_out_0  = data0_q;
    assign data_out_1  = data1_q;
    assign valid_out_0 = valid0_q;
    assign valid_out_1 = valid1_q;
    assign sync_0      = in_sync_0;
    assign sync_1      = in_sync_1;
    assign active_out  = both_sync;

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Table-driven bench for phy_rx_sync_ctrl with hand-computed expectations,
// plus a hand-written asynchronous reset sequence.
module tb_phy_rx_sync_ctrl;

    typedef struct {
        logic       en;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       e0;
        logic       e1;
        logic [7:0] xd0;
        logic [7:0] xd1;
        logic       xv0;
        logic       xv1;
        logic       xs0;
        logic       xs1;
    } vec_t;

    logic       clk_f = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] data_in_0 = 8'h00, data_in_1 = 8'h00;
    logic       err_in_0 = 1'b0, err_in_1 = 1'b0;
    logic [7:0] data_out_0, data_out_1;
    logic       valid_out_0, valid_out_1, sync_0, sync_1, active_out;

    int   testCount = 0;
    int   failCount = 0;
    vec_t vecs[$];

    phy_rx_sync_ctrl dut (
        .clk_f(clk_f), .reset(reset), .enable(enable),
        .data_in_0(data_in_0), .data_in_1(data_in_1),
        .err_in_0(err_in_0), .err_in_1(err_in_1),
        .data_out_0(data_out_0), .data_out_1(data_out_1),
        .valid_out_0(valid_out_0), .valid_out_1(valid_out_1),
        .sync_0(sync_0), .sync_1(sync_1), .active_out(active_out)
    );

    always #5 clk_f = ~clk_f;

    task automatic checkField(input string name, input int row, input logic [7:0] got, input logic [7:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s step %0d: got %h expected %h", name, row, got, exp);
        end
    endtask

    task automatic checkOutput(input int row, input vec_t v);
        checkField("data_out_0", row, data_out_0, v.xd0);
        checkField("data_out_1", row, data_out_1, v.xd1);
        checkField("valid_out_0", row, {7'd0, valid_out_0}, {7'd0, v.xv0});
        checkField("valid_out_1", row, {7'd0, valid_out_1}, {7'd0, v.xv1});
        checkField("sync_0", row, {7'd0, sync_0}, {7'd0, v.xs0});
        checkField("sync_1", row, {7'd0, sync_1}, {7'd0, v.xs1});
        checkField("active_out", row, {7'd0, active_out}, {7'd0, v.xs0 & v.xs1});
    endtask

    task automatic applyStimulus(input int row, input vec_t v);
        enable    = v.en;
        data_in_0 = v.d0;
        data_in_1 = v.d1;
        err_in_0  = v.e0;
        err_in_1  = v.e1;
        @(posedge clk_f);
        #1;
        checkOutput(row, v);
    endtask

    task automatic addVec(input logic en, input logic [7:0] d0, input logic [7:0] d1,
                          input logic e0, input logic e1,
                          input logic [7:0] xd0, input logic [7:0] xd1,
                          input logic xv0, input logic xv1, input logic xs0, input logic xs1);
        vec_t v;
        v.en = en; v.d0 = d0; v.d1 = d1; v.e0 = e0; v.e1 = e1;
        v.xd0 = xd0; v.xd1 = xd1; v.xv0 = xv0; v.xv1 = xv1; v.xs0 = xs0; v.xs1 = xs1;
        vecs.push_back(v);
    endtask

    initial begin
        vec_t v;

        // Acquisition on both lanes, then first data (lane 1 idles).
        for (int i = 0; i < 3; i++) addVec(1, 8'hBC, 8'hBC, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        addVec(1, 8'hBC, 8'hBC, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1);
        addVec(1, 8'hEC, 8'hBC, 0, 0, 8'hEC, 8'h00, 1, 0, 1, 1);
        addVec(1, 8'hAC, 8'h0C, 0, 0, 8'hAC, 8'h0C, 1, 1, 1, 1);
        // Idle removal while in SYNC.
        addVec(1, 8'h99, 8'h11, 0, 0, 8'h99, 8'h11, 1, 1, 1, 1);
        addVec(1, 8'hBC, 8'hBC, 0, 0, 8'h99, 8'h11, 0, 0, 1, 1);
        addVec(1, 8'h88, 8'h22, 0, 0, 8'h88, 8'h22, 1, 1, 1, 1);
        // Three lane-1 errors, a good byte resets the run, then four errors lose sync.
        for (int i = 0; i < 3; i++) addVec(1, 8'hBC, 8'h55, 0, 1, 8'h88, 8'h22, 0, 0, 1, 1);
        addVec(1, 8'hBC, 8'h66, 0, 0, 8'h88, 8'h66, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) addVec(1, 8'hBC, 8'h55, 0, 1, 8'h88, 8'h66, 0, 0, 1, 1);
        addVec(1, 8'hBC, 8'h55, 0, 1, 8'h88, 8'h66, 0, 0, 1, 0);
        addVec(1, 8'h33, 8'hBC, 0, 0, 8'h33, 8'h66, 0, 0, 1, 0);
        addVec(1, 8'h34, 8'hBC, 0, 0, 8'h34, 8'h66, 0, 0, 1, 0);
        // Disable clears both lanes; data holds.
        addVec(0, 8'h35, 8'hBC, 0, 0, 8'h34, 8'h66, 0, 0, 0, 0);
        // Comma run broken after three; an errored comma also does not count.
        for (int i = 0; i < 3; i++) addVec(1, 8'hBC, 8'hBC, 0, 0, 8'h34, 8'h66, 0, 0, 0, 0);
        addVec(1, 8'hAA, 8'hAA, 0, 0, 8'h34, 8'h66, 0, 0, 0, 0);
        addVec(1, 8'hBC, 8'hBC, 0, 0, 8'h34, 8'h66, 0, 0, 0, 0);
        addVec(1, 8'hBC, 8'hBC, 1, 1, 8'h34, 8'h66, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) addVec(1, 8'hBC, 8'hBC, 0, 0, 8'h34, 8'h66, 0, 0, 0, 0);
        addVec(1, 8'hBC, 8'hBC, 0, 0, 8'h34, 8'h66, 0, 0, 1, 1);
        addVec(1, 8'h12, 8'h34, 0, 0, 8'h12, 8'h34, 1, 1, 1, 1);
        // Skewed acquisition: lane 0 leads lane 1 by two bytes.
        addVec(0, 8'h00, 8'h00, 0, 0, 8'h12, 8'h34, 0, 0, 0, 0);
        addVec(1, 8'hBC, 8'h00, 0, 0, 8'h12, 8'h34, 0, 0, 0, 0);
        addVec(1, 8'hBC, 8'h00, 0, 0, 8'h12, 8'h34, 0, 0, 0, 0);
        addVec(1, 8'hBC, 8'hBC, 0, 0, 8'h12, 8'h34, 0, 0, 0, 0);
        addVec(1, 8'hBC, 8'hBC, 0, 0, 8'h12, 8'h34, 0, 0, 1, 0);
        addVec(1, 8'h41, 8'hBC, 0, 0, 8'h41, 8'h34, 0, 0, 1, 0);
        addVec(1, 8'h42, 8'hBC, 0, 0, 8'h42, 8'h34, 0, 0, 1, 1);
        addVec(1, 8'h43, 8'h44, 0, 0, 8'h43, 8'h44, 1, 1, 1, 1);
        // One disabled cycle in SYNC forces a full reacquisition.
        addVec(0, 8'h55, 8'h55, 0, 0, 8'h43, 8'h44, 0, 0, 0, 0);
        addVec(1, 8'h66, 8'h77, 0, 0, 8'h43, 8'h44, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) addVec(1, 8'hBC, 8'hBC, 0, 0, 8'h43, 8'h44, 0, 0, 0, 0);
        addVec(1, 8'hBC, 8'hBC, 0, 0, 8'h43, 8'h44, 0, 0, 1, 1);
        addVec(1, 8'h5A, 8'hA5, 0, 0, 8'h5A, 8'hA5, 1, 1, 1, 1);
        addVec(1, 8'h77, 8'h88, 0, 0, 8'h77, 8'h88, 1, 1, 1, 1);

        #2;
        v = '{en: 0, d0: 0, d1: 0, e0: 0, e1: 0, xd0: 0, xd1: 0, xv0: 0, xv1: 0, xs0: 0, xs1: 0};
        checkOutput(-1, v);
        @(negedge clk_f);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);

        // Asynchronous reset between edges clears everything at once.
        data_in_0 = 8'h99;
        data_in_1 = 8'h98;
        #3;
        reset = 1'b1;
        #1;
        checkOutput(1000, v);
        @(negedge clk_f);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v = '{en: 1, d0: 8'hBC, d1: 8'hBC, e0: 0, e1: 0, xd0: 0, xd1: 0, xv0: 0, xv1: 0, xs0: 0, xs1: 0};
            applyStimulus(1001 + i, v);
        end
        v = '{en: 1, d0: 8'hBC, d1: 8'hBC, e0: 0, e1: 0, xd0: 0, xd1: 0, xv0: 0, xv1: 0, xs0: 1, xs1: 1};
        applyStimulus(1004, v);
        v = '{en: 1, d0: 8'h5B, d1: 8'h6C, e0: 0, e1: 0, xd0: 8'h5B, xd1: 8'h6C, xv0: 1, xv1: 1, xs0: 1, xs1: 1};
        applyStimulus(1005, v);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
